// File: rtl/uart_tx_if.sv
// Parallel-side bundle of the UART transmitter: word, strobe, frame configuration
// and the serial line plus busy flag coming back.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    // Handshake: DATA_VALID is a one-cycle strobe that is only taken while Busy=0;
    // P_DATA, PAR_EN, PAR_TYP and Prescale must be valid in that same cycle and
    // are free to change afterwards. A strobe seen while Busy=1 is dropped.
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit, each bit
// lasting Prescale clock cycles of the shared oversampled clock.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    uart_tx_if.slave   bus,
    output logic [2:0] dbg_state
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [5:0]            cnt;
    logic [5:0]            prescale_r;
    logic [BW-1:0]         bit_cnt;
    logic                  par_en_r;
    logic                  par_bit;
    logic                  tx_out_r;
    logic                  busy_r;
    logic                  bit_end;

    assign bit_end    = (cnt == prescale_r - 6'd1);
    assign bus.TX_OUT = tx_out_r;
    assign bus.Busy   = busy_r;
    assign dbg_state  = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            shift_reg  <= '0;
            cnt        <= '0;
            prescale_r <= 6'd1;
            bit_cnt    <= '0;
            par_en_r   <= 1'b0;
            par_bit    <= 1'b0;
            tx_out_r   <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            // The period counter runs in every non-idle state; each state only
            // decides what happens on its bit boundary.
            if (state != IDLE) begin
                cnt <= bit_end ? 6'd0 : cnt + 6'd1;
            end
            case (state)
                IDLE: begin
                    tx_out_r <= 1'b1;
                    busy_r   <= 1'b0;
                    cnt      <= '0;
                    bit_cnt  <= '0;
                    if (bus.DATA_VALID) begin
                        shift_reg  <= bus.P_DATA;
                        par_en_r   <= bus.PAR_EN;
                        par_bit    <= (^bus.P_DATA) ^ bus.PAR_TYP;
                        prescale_r <= (bus.Prescale == 6'd0) ? 6'd1 : bus.Prescale;
                        tx_out_r   <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_out_r <= shift_reg[0];
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            if (par_en_r) begin
                                tx_out_r <= par_bit;
                                state    <= PARITY;
                            end else begin
                                tx_out_r <= 1'b1;
                                state    <= STOP;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            tx_out_r <= shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_out_r <= 1'b1;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx_out_r <= 1'b1;
                    busy_r   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: checks whole frames bit by bit against hand-derived
// bit patterns and decodes one frame the way a receiver would.
module tb_uart_tx;
    logic       CLK;
    logic       RST;
    logic [2:0] dbg_state;
    int         n_checks;
    int         n_fail;
    logic       tx_q[$];

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; the strobe is seen by the next posedge.
    task automatic send(input logic [7:0] data, input logic pen, input logic ptyp,
                        input logic [5:0] presc);
        bus.P_DATA     = data;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.Prescale   = presc;
        bus.DATA_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.DATA_VALID = 1'b0;
    endtask

    // Records TX_OUT at every negedge while Busy is high.
    task automatic capture_frame(output int busy_cycles);
        busy_cycles = 0;
        tx_q.delete();
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (bus.Busy !== 1'b1) break;
            tx_q.push_back(bus.TX_OUT);
            busy_cycles++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            bus.P_DATA     = 8'($urandom_range(0, 255));
            bus.DATA_VALID = 1'($urandom_range(0, 1));
            bus.PAR_EN     = 1'($urandom_range(0, 1));
            bus.PAR_TYP    = 1'($urandom_range(0, 1));
            bus.Prescale   = 6'($urandom_range(0, 63));
            n_checks++;
            if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0 || dbg_state !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: tx=%b busy=%b state=%0d, want tx=1 busy=0 state=0",
                         i, bus.TX_OUT, bus.Busy, dbg_state);
            end
        end
        bus.DATA_VALID = 1'b0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: tx=%b busy=%b, want tx=1 busy=0", bus.TX_OUT, bus.Busy);
        end
    endtask

    task automatic test_even_parity();
        int         bc;
        logic [10:0] exp_bits = 11'b1_0_10100101_0;
        logic       bad;
        @(negedge CLK);
        send(8'hA5, 1'b1, 1'b0, 6'd8);
        capture_frame(bc);
        n_checks++;
        if (bc !== 88) begin
            n_fail++;
            $display("FAIL even_busy_len: got %0d cycles, want 88", bc);
        end
        for (int b = 0; b < 11; b++) begin
            bad = 1'b0;
            for (int c = 0; c < 8; c++) if (tx_q[b*8+c] !== exp_bits[b]) bad = 1'b1;
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL even_bit%0d: got %b, want %b", b, tx_q[b*8], exp_bits[b]);
            end
        end
    endtask

    task automatic test_odd_parity();
        int         bc;
        logic [10:0] exp_bits = 11'b1_1_11111111_0;
        logic       bad;
        @(negedge CLK);
        send(8'hFF, 1'b1, 1'b1, 6'd16);
        capture_frame(bc);
        n_checks++;
        if (bc !== 176) begin
            n_fail++;
            $display("FAIL odd_busy_len: got %0d cycles, want 176", bc);
        end
        for (int b = 0; b < 11; b++) begin
            bad = 1'b0;
            for (int c = 0; c < 16; c++) if (tx_q[b*16+c] !== exp_bits[b]) bad = 1'b1;
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL odd_bit%0d: got %b, want %b", b, tx_q[b*16], exp_bits[b]);
            end
        end
    endtask

    task automatic test_no_parity();
        int   bc;
        logic bad;
        @(negedge CLK);
        send(8'h00, 1'b0, 1'b1, 6'd32);
        capture_frame(bc);
        n_checks++;
        if (bc !== 320) begin
            n_fail++;
            $display("FAIL nopar_busy_len: got %0d cycles, want 320", bc);
        end
        bad = 1'b0;
        for (int c = 0; c < 288; c++) if (tx_q[c] !== 1'b0) bad = 1'b1;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL nopar_low_run: line not low for 288 cycles, want 0");
        end
        bad = 1'b0;
        for (int c = 288; c < 320; c++) if (tx_q[c] !== 1'b1) bad = 1'b1;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL nopar_stop: line not high for final 32 cycles, want 1");
        end
    endtask

    task automatic test_prescale_zero();
        int         bc;
        logic [10:0] exp_bits = 11'b1_1_10010110_0;
        @(negedge CLK);
        send(8'h96, 1'b1, 1'b1, 6'd0);
        capture_frame(bc);
        n_checks++;
        if (bc !== 11) begin
            n_fail++;
            $display("FAIL p0_busy_len: got %0d cycles, want 11", bc);
        end
        for (int b = 0; b < 11; b++) begin
            n_checks++;
            if (tx_q[b] !== exp_bits[b]) begin
                n_fail++;
                $display("FAIL p0_bit%0d: got %b, want %b", b, tx_q[b], exp_bits[b]);
            end
        end
    endtask

    task automatic test_busy_protection();
        int         bc;
        logic [10:0] exp_bits = 11'b1_0_00111100_0;
        logic       bad;
        @(negedge CLK);
        send(8'h3C, 1'b1, 1'b0, 6'd8);
        fork
            capture_frame(bc);
            begin
                repeat (20) @(negedge CLK);
                bus.P_DATA     = 8'hC3;
                bus.PAR_TYP    = 1'b1;
                bus.PAR_EN     = 1'b0;
                bus.Prescale   = 6'd3;
                bus.DATA_VALID = 1'b1;
                @(negedge CLK);
                bus.DATA_VALID = 1'b0;
            end
        join
        n_checks++;
        if (bc !== 88) begin
            n_fail++;
            $display("FAIL prot_busy_len: got %0d cycles, want 88", bc);
        end
        for (int b = 0; b < 11; b++) begin
            bad = 1'b0;
            for (int c = 0; c < 8; c++) if (tx_q[b*8+c] !== exp_bits[b]) bad = 1'b1;
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL prot_bit%0d: got %b, want %b", b, tx_q[b*8], exp_bits[b]);
            end
        end
        bad = 1'b0;
        repeat (60) begin
            @(negedge CLK);
            if (bus.Busy !== 1'b0 || bus.TX_OUT !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL prot_no_second_frame: line left idle, want busy=0 tx=1");
        end
    endtask

    task automatic test_back_to_back();
        int          bc;
        logic [9:0]  exp_bits = 10'b1_10000000_0;
        @(negedge CLK);
        send(8'h01, 1'b0, 1'b0, 6'd2);
        capture_frame(bc);
        n_checks++;
        if (bc !== 20) begin
            n_fail++;
            $display("FAIL b2b_first_len: got %0d cycles, want 20", bc);
        end
        // Busy was just seen low: strobe again immediately.
        send(8'h80, 1'b0, 1'b0, 6'd2);
        capture_frame(bc);
        n_checks++;
        if (bc !== 20) begin
            n_fail++;
            $display("FAIL b2b_second_len: got %0d cycles, want 20", bc);
        end
        for (int b = 0; b < 10; b++) begin
            n_checks++;
            if (tx_q[b*2] !== exp_bits[b] || tx_q[b*2+1] !== exp_bits[b]) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: got %b, want %b", b, tx_q[b*2], exp_bits[b]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int          bc;
        logic [10:0] exp_bits = 11'b1_0_01011010_0;
        logic [7:0]  rx;
        logic        par_s;
        logic        stop_s;
        logic        bad;
        @(negedge CLK);
        send(8'hA5, 1'b0, 1'b0, 6'd8);
        repeat (36) @(negedge CLK);
        n_checks++;
        if (bus.TX_OUT !== 1'b0 || bus.Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_reset: tx=%b busy=%b, want tx=0 busy=1", bus.TX_OUT, bus.Busy);
        end
        RST = 1'b0;
        #1;
        n_checks++;
        if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset: tx=%b busy=%b state=%0d, want tx=1 busy=0 state=0",
                     bus.TX_OUT, bus.Busy, dbg_state);
        end
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send(8'h5A, 1'b1, 1'b0, 6'd8);
        capture_frame(bc);
        n_checks++;
        if (bc !== 88) begin
            n_fail++;
            $display("FAIL loop_busy_len: got %0d cycles, want 88", bc);
        end
        for (int b = 0; b < 11; b++) begin
            bad = 1'b0;
            for (int c = 0; c < 8; c++) if (tx_q[b*8+c] !== exp_bits[b]) bad = 1'b1;
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL loop_bit%0d: got %b, want %b", b, tx_q[b*8], exp_bits[b]);
            end
        end
        // Receiver view: sample each bit at its midpoint.
        for (int i = 0; i < 8; i++) rx[i] = tx_q[(1+i)*8 + 4];
        par_s  = tx_q[9*8 + 4];
        stop_s = tx_q[10*8 + 4];
        n_checks++;
        if (rx !== 8'h5A) begin
            n_fail++;
            $display("FAIL loop_rx_word: got %h, want 5a", rx);
        end
        n_checks++;
        if ((^rx) !== par_s) begin
            n_fail++;
            $display("FAIL loop_rx_parity: parity bit %b, want %b", par_s, ^rx);
        end
        n_checks++;
        if (stop_s !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_rx_stop: got %b, want 1", stop_s);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        RST            = 1'b0;
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd1;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_prescale_zero();
        test_busy_protection();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
